systolic_result_drain: RTL and testbench

SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

---
 rtl/systolic_pkg.sv | 28 ++
 rtl/rc_index_counter.sv | 52 +++++
 rtl/systolic_result_drain.sv | 153 +++++++++++++++
 tb/tb_systolic_result_drain.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_pkg
//  Purpose  : Types and defaults shared by the systolic array, its controller
//             and the result drain.
//             - drain_state_t : drain FSM state encoding
//             - DEFAULT_N / DEFAULT_DATA_SIZE : array dimension / result width
//             - idx_width()   : index width that stays >= 1 when n == 1
//  Revision : 1.0  initial release
// ============================================================================
package systolic_pkg;

    localparam int DEFAULT_N         = 16;
    localparam int DEFAULT_DATA_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } drain_state_t;

    // $clog2(1) is 0, which would give zero-width index ports for a 1x1 array.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rc_index_counter.sv
`default_nettype none
// ============================================================================
//  Module   : rc_index_counter
//  Purpose  : Row-major (row, col) sequencer for an N x N result array.
//  Ports    : clk, reset   - clock, synchronous active-high reset
//             advance      - step to the next element (col first, then row)
//             clear        - return to (0,0); wins over advance
//             row, col     - current element indices
//             last         - current element is (N-1, N-1)
//  Revision : 1.0  initial release
// ============================================================================
module rc_index_counter
    import systolic_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    input  logic          clear,
    output logic [IW-1:0] row,
    output logic [IW-1:0] col,
    output logic          last
);

    localparam logic [IW-1:0] C_MAX_IDX = IW'(N - 1);
    localparam logic [IW-1:0] C_ONE     = IW'(1);

    logic [IW-1:0] r_row;
    logic [IW-1:0] r_col;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (advance) begin
            if (r_col == C_MAX_IDX) begin
                r_col <= '0;
                r_row <= (r_row == C_MAX_IDX) ? '0 : r_row + C_ONE;
            end else begin
                r_col <= r_col + C_ONE;
            end
        end
    end

    assign row  = r_row;
    assign col  = r_col;
    assign last = (r_row == C_MAX_IDX) && (r_col == C_MAX_IDX);

endmodule
`default_nettype wire

// File: rtl/systolic_result_drain.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_result_drain
//  Purpose  : Snapshots the N x N accumulator sums of a systolic array when
//             'start' pulses, asks the array to clear, then streams the
//             snapshot out in row-major order over a valid/ready interface.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             start                 - sums on sum_bus are final this cycle
//             sum_bus               - flattened sums, (r,c) at
//                                     [(r*N+c)*DATA_SIZE +: DATA_SIZE]
//             out_ready             - consumer accepts the presented result
//             out_valid/out_data    - presented result
//             out_row/out_col       - indices of the presented result
//             out_last              - presented result is (N-1,N-1)
//             busy                  - streaming in progress
//             array_clear           - one-cycle accumulator clear request
//             done                  - one-cycle pulse after the final transfer
//  Revision : 1.0  initial release
// ============================================================================
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter  int N         = DEFAULT_N,
    parameter  int DATA_SIZE = DEFAULT_DATA_SIZE,
    localparam int IW        = idx_width(N)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [N*N*DATA_SIZE-1:0]  sum_bus,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [DATA_SIZE-1:0]      out_data,
    output logic [IW-1:0]             out_row,
    output logic [IW-1:0]             out_col,
    output logic                      out_last,
    output logic                      busy,
    output logic                      array_clear,
    output logic                      done
);

    localparam int FW = idx_width(N * N);

    drain_state_t         r_state;
    drain_state_t         w_next;
    logic                 w_capture;
    logic                 w_advance;
    logic                 w_cnt_clear;
    logic                 w_last;
    logic [IW-1:0]        w_row;
    logic [IW-1:0]        w_col;
    logic [FW-1:0]        w_flat;
    logic [DATA_SIZE-1:0] r_buffer [N*N];
    logic                 r_array_clear;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        w_capture   = 1'b0;
        w_advance   = 1'b0;
        w_cnt_clear = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_capture   = 1'b1;
                    w_cnt_clear = 1'b1;
                    w_next      = STREAM;
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    w_advance = 1'b1;
                    if (w_last) begin
                        w_next = DONE;
                    end
                end
            end
            DONE: begin
                done        = 1'b1;
                w_cnt_clear = 1'b1;
                w_next      = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Snapshot buffer: written only on the IDLE capture edge, never reset,
    // so later activity on sum_bus cannot disturb a stream in progress.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_capture && !reset) begin
            for (int i = 0; i < N * N; i++) begin
                r_buffer[i] <= sum_bus[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    // The clear request lands in the first STREAM cycle, when the snapshot
    // is already safely held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_array_clear <= 1'b0;
        end else begin
            r_array_clear <= w_capture;
        end
    end

    rc_index_counter #(
        .N  (N),
        .IW (IW)
    ) u_rc_index_counter (
        .clk     (clk),
        .reset   (reset),
        .advance (w_advance),
        .clear   (w_cnt_clear),
        .row     (w_row),
        .col     (w_col),
        .last    (w_last)
    );

    // ------------------------------------------------------------------
    // Output mux
    // ------------------------------------------------------------------
    assign w_flat      = FW'(w_row) * FW'(N) + FW'(w_col);
    assign out_data    = r_buffer[w_flat];
    assign out_row     = w_row;
    assign out_col     = w_col;
    assign out_last    = out_valid && w_last;
    assign array_clear = r_array_clear;

endmodule
`default_nettype wire

// File: tb/tb_systolic_result_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_result_drain
//  Purpose  : Scoreboard bench for systolic_result_drain; one N=2 instance for
//             directed cases and one default N=16 instance for a full drain
//             under random backpressure.
//  Revision : 1.0  initial release
// ============================================================================
module tb_systolic_result_drain;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] row;
        logic [3:0] col;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- N=2 instance ----------------
    logic        start2;
    logic [31:0] sum2;
    logic        ready2;
    logic        valid2, last2, busy2, clear2, done2;
    logic [7:0]  data2;
    logic [0:0]  row2, col2;

    systolic_result_drain #(.N(2), .DATA_SIZE(8)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .sum_bus(sum2),
        .out_ready(ready2), .out_valid(valid2), .out_data(data2),
        .out_row(row2), .out_col(col2), .out_last(last2),
        .busy(busy2), .array_clear(clear2), .done(done2)
    );

    // ---------------- N=16 instance ----------------
    logic          start16;
    logic [2047:0] sum16;
    logic          ready16;
    logic          valid16, last16, busy16, clear16, done16;
    logic [7:0]    data16;
    logic [3:0]    row16, col16;
    int            n16 = 0;

    systolic_result_drain dut16 (
        .clk(clk), .reset(reset), .start(start16), .sum_bus(sum16),
        .out_ready(ready16), .out_valid(valid16), .out_data(data16),
        .out_row(row16), .out_col(col16), .out_last(last16),
        .busy(busy16), .array_clear(clear16), .done(done16)
    );

    exp_t q2[$];
    exp_t q16[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push2(input logic [7:0] d, input int r, input int c, input logic l);
        exp_t e;
        e.data = d; e.row = 4'(r); e.col = 4'(c); e.last = l;
        q2.push_back(e);
    endtask

    // (0,0)=a, (0,1)=b, (1,0)=c, (1,1)=d in row-major order, last on d
    task automatic push_vec2(input logic [31:0] v);
        for (int i = 0; i < 4; i++) begin
            push2(v[i*8 +: 8], i / 2, i % 2, i == 3);
        end
    endtask

    task automatic start_n2(input logic [31:0] v);
        @(posedge clk); #1 start2 = 1'b1; sum2 = v;
        @(posedge clk); #1 start2 = 1'b0; sum2 = {4{8'hAA}};
    endtask

    task automatic wait_done2(input int maxc);
        bit seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            if (done2) seen = 1'b1;
        end
        chk("done2_seen", {31'd0, seen}, 32'd1);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (valid2 === 1'b1 && ready2 === 1'b1) begin
            exp_t e;
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL n2_unexpected: got data %0h row %0d col %0d, required no output", data2, row2, col2);
            end else begin
                e = q2.pop_front();
                chk("n2_data", {24'd0, data2}, {24'd0, e.data});
                chk("n2_row",  {31'd0, row2},  {28'd0, e.row});
                chk("n2_col",  {31'd0, col2},  {28'd0, e.col});
                chk("n2_last", {31'd0, last2}, {31'd0, e.last});
            end
        end
    end

    always @(negedge clk) begin
        if (valid16 === 1'b1 && ready16 === 1'b1) begin
            exp_t e;
            n16++;
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL n16_unexpected: got data %0h, required no output", data16);
            end else begin
                e = q16.pop_front();
                chk("n16_data", {24'd0, data16}, {24'd0, e.data});
                chk("n16_row",  {28'd0, row16},  {28'd0, e.row});
                chk("n16_col",  {28'd0, col16},  {28'd0, e.col});
                chk("n16_last", {31'd0, last16}, {31'd0, e.last});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    localparam logic [31:0] VEC1 = {8'd255, 8'd11, 8'd7, 8'd3};
    localparam logic [31:0] VEC2 = {8'h80, 8'h01, 8'd7, 8'h42};

    initial begin
        reset = 1'b1; start2 = 1'b0; sum2 = '0; ready2 = 1'b1;
        start16 = 1'b0; sum16 = '0; ready16 = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // ---- reset state ----
        @(negedge clk);
        chk("rst_valid", {31'd0, valid2}, 32'd0);
        chk("rst_busy",  {31'd0, busy2},  32'd0);
        chk("rst_done",  {31'd0, done2},  32'd0);
        chk("rst_clear", {31'd0, clear2}, 32'd0);
        chk("rst_last",  {31'd0, last2},  32'd0);
        chk("rst_row",   {31'd0, row2},   32'd0);
        chk("rst_col",   {31'd0, col2},   32'd0);

        // ---- basic stream, capture isolation, start ignored while streaming ----
        push_vec2(VEC1);
        start_n2(VEC1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("t1_valid_k%0d", k), {31'd0, valid2}, {31'd0, k < 4});
            chk($sformatf("t1_last_k%0d", k),  {31'd0, last2},  {31'd0, k == 3});
            chk($sformatf("t1_clear_k%0d", k), {31'd0, clear2}, {31'd0, k == 0});
            chk($sformatf("t1_done_k%0d", k),  {31'd0, done2},  {31'd0, k == 4});
            chk($sformatf("t1_busy_k%0d", k),  {31'd0, busy2},  {31'd0, k < 4});
            @(posedge clk); #1 start2 = (k == 1);
        end
        start2 = 1'b0;
        chk("t1_queue_empty", q2.size(), 32'd0);

        // ---- backpressure on (0,1) for 3 cycles ----
        push_vec2(VEC2);
        start_n2(VEC2);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("t2_valid_k%0d", k), {31'd0, valid2}, {31'd0, k < 7});
            chk($sformatf("t2_done_k%0d", k),  {31'd0, done2},  {31'd0, k == 7});
            if (k >= 1 && k <= 3) begin
                chk($sformatf("t2_hold_data_k%0d", k), {24'd0, data2}, 32'd7);
                chk($sformatf("t2_hold_row_k%0d", k),  {31'd0, row2},  32'd0);
                chk($sformatf("t2_hold_col_k%0d", k),  {31'd0, col2},  32'd1);
            end
            @(posedge clk); #1 ready2 = !(k <= 2);
        end
        chk("t2_queue_empty", q2.size(), 32'd0);

        // ---- reset after two transfers, then restart from (0,0) ----
        push2(8'd3, 0, 0, 1'b0);
        push2(8'd7, 0, 1, 1'b0);
        start_n2(VEC1);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1 reset = 1'b1; ready2 = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 reset = 1'b0; ready2 = 1'b1;
        @(negedge clk);
        chk("t3_valid", {31'd0, valid2}, 32'd0);
        chk("t3_busy",  {31'd0, busy2},  32'd0);
        chk("t3_row",   {31'd0, row2},   32'd0);
        chk("t3_col",   {31'd0, col2},   32'd0);
        chk("t3_queue_empty", q2.size(), 32'd0);
        push_vec2(VEC1);
        start_n2(VEC1);
        wait_done2(20);
        chk("t3_restart_queue_empty", q2.size(), 32'd0);

        // ---- N=16 full drain under random out_ready ----
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                exp_t e;
                sum16[(r*16+c)*8 +: 8] = 8'(r * 16 + c);
                e.data = 8'(r * 16 + c); e.row = 4'(r); e.col = 4'(c);
                e.last = (r == 15) && (c == 15);
                q16.push_back(e);
            end
        end
        @(posedge clk); #1 start16 = 1'b1;
        @(posedge clk); #1 start16 = 1'b0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 4000 && !seen; i++) begin
                ready16 = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (done16) seen = 1'b1;
                @(posedge clk); #1;
            end
            chk("n16_done_seen", {31'd0, seen}, 32'd1);
        end
        chk("n16_transfers", n16, 32'd256);
        chk("n16_queue_empty", q16.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
